blk_00cb50: RTL

Write-request burst splitter for the output_drainer fp32 output m_axi write path. It sits directly upstream of the AW throttle and the W-channel burst/response FIFOs inside the m_axi write unit. It takes one HLS write request (start byte address, length in beats) and splits it into AXI INCR bursts. Each burst is capped at MAX_BURST_LEN beats and never crosses a 4 KB boundary. For every burst it also emits a control record: beats-1, plus a flag marking the last burst of the request.

---
 rtl/blk_00cb50_if.sv | 30 +++
 rtl/blk_00cb50.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/blk_00cb50_if.sv
// Request / burst / control bundle of the m_axi write-request splitter.
// The slave modport is the splitter's view; the master modport is its environment.
interface blk_00cb50_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] in_REQ_ADDR;
    logic [31:0]           in_REQ_LEN;
    logic                  in_REQ_VALID;
    logic                  out_REQ_READY;
    logic [ADDR_WIDTH-1:0] out_BURST_ADDR;
    logic [7:0]            out_BURST_LEN;
    logic                  out_BURST_VALID;
    logic                  in_BURST_READY;
    logic                  out_CTRL_INFO;
    logic [7:0]            out_CTRL_LEN;
    logic                  out_CTRL_VALID;
    logic                  in_CTRL_READY;

    modport slave (
        input  in_REQ_ADDR, in_REQ_LEN, in_REQ_VALID, in_BURST_READY, in_CTRL_READY,
        output out_REQ_READY, out_BURST_ADDR, out_BURST_LEN, out_BURST_VALID,
               out_CTRL_INFO, out_CTRL_LEN, out_CTRL_VALID
    );

    modport master (
        output in_REQ_ADDR, in_REQ_LEN, in_REQ_VALID, in_BURST_READY, in_CTRL_READY,
        input  out_REQ_READY, out_BURST_ADDR, out_BURST_LEN, out_BURST_VALID,
               out_CTRL_INFO, out_CTRL_LEN, out_CTRL_VALID
    );
endinterface

// File: rtl/blk_00cb50.sv
// Splits one write request into AXI INCR bursts capped at MAX_BURST_LEN beats that never
// cross a 4 KB boundary, emitting a matching control record (beats-1, last flag) per burst.
module blk_00cb50 #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            ACLK_EN,
    blk_00cb50_if.slave     bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam logic [12:0]           MAX_BEATS  = 13'(MAX_BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    logic [31:0]           rem_r;
    logic [ADDR_WIDTH-1:0] burst_addr_r;
    logic [7:0]            burst_len_r;
    logic                  burst_valid_r;
    logic                  ctrl_info_r;
    logic [7:0]            ctrl_len_r;
    logic                  ctrl_valid_r;

    logic                  req_ready_s;
    logic                  req_accept_s;
    logic                  burst_hs_s;
    logic                  ctrl_hs_s;
    logic                  emit_done_s;
    logic [12:0]           to4k_s;
    logic [12:0]           lim_s;
    logic [12:0]           beats_s;

    assign req_accept_s = bus.in_REQ_VALID & req_ready_s & ACLK_EN;
    assign burst_hs_s   = burst_valid_r & bus.in_BURST_READY & ACLK_EN;
    assign ctrl_hs_s    = ctrl_valid_r & bus.in_CTRL_READY & ACLK_EN;
    // Each channel is done once its valid is already low or it handshakes this cycle.
    assign emit_done_s  = (~burst_valid_r | burst_hs_s) & (~ctrl_valid_r | ctrl_hs_s);

    // Burst size: min of remaining beats, the burst cap and beats left before the 4 KB page end.
    always_comb begin
        to4k_s = (13'd4096 - {1'b0, cur_addr_r[11:0]}) >> ALIGN;
        if (to4k_s < MAX_BEATS) begin
            lim_s = to4k_s;
        end else begin
            lim_s = MAX_BEATS;
        end
        if (rem_r < {19'd0, lim_s}) begin
            beats_s = rem_r[12:0];
        end else begin
            beats_s = lim_s;
        end
    end

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r <= IDLE;
        end else if (ACLK_EN) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state logic; zero-length requests are consumed without leaving IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_accept_s && (bus.in_REQ_LEN != 32'd0)) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: state_next_s = EMIT;
            EMIT: begin
                if (emit_done_s) begin
                    state_next_s = (rem_r != 32'd0) ? CALC : IDLE;
                end else begin
                    state_next_s = EMIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: a request is only accepted while idle and out of reset.
    always_comb begin
        req_ready_s = (state_r == IDLE) && !ARESET;
    end

    // Request bookkeeping and registered burst/control outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cur_addr_r    <= '0;
            rem_r         <= 32'd0;
            burst_addr_r  <= '0;
            burst_len_r   <= 8'd0;
            burst_valid_r <= 1'b0;
            ctrl_info_r   <= 1'b0;
            ctrl_len_r    <= 8'd0;
            ctrl_valid_r  <= 1'b0;
        end else if (ACLK_EN) begin
            case (state_r)
                IDLE: begin
                    if (req_accept_s) begin
                        cur_addr_r <= bus.in_REQ_ADDR & ALIGN_MASK;
                        rem_r      <= bus.in_REQ_LEN;
                    end
                end
                CALC: begin
                    burst_addr_r  <= cur_addr_r;
                    burst_len_r   <= 8'(beats_s - 13'd1);
                    ctrl_len_r    <= 8'(beats_s - 13'd1);
                    ctrl_info_r   <= (rem_r == {19'd0, beats_s});
                    cur_addr_r    <= cur_addr_r + (ADDR_WIDTH'(beats_s) << ALIGN);
                    rem_r         <= rem_r - {19'd0, beats_s};
                    burst_valid_r <= 1'b1;
                    ctrl_valid_r  <= 1'b1;
                end
                EMIT: begin
                    if (burst_hs_s) begin
                        burst_valid_r <= 1'b0;
                    end
                    if (ctrl_hs_s) begin
                        ctrl_valid_r <= 1'b0;
                    end
                end
                default: begin
                    burst_valid_r <= 1'b0;
                    ctrl_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_REQ_READY   = req_ready_s;
    assign bus.out_BURST_ADDR  = burst_addr_r;
    assign bus.out_BURST_LEN   = burst_len_r;
    assign bus.out_BURST_VALID = burst_valid_r;
    assign bus.out_CTRL_INFO   = ctrl_info_r;
    assign bus.out_CTRL_LEN    = ctrl_len_r;
    assign bus.out_CTRL_VALID  = ctrl_valid_r;
endmodule
